// File: rtl/fft_addr_gen_if.sv
// Handshake and address bus between the FFT address sequencer and the butterfly unit.
// The master modport is the sequencer and the slave modport is its consumer.
interface fft_addr_gen_if #(
    parameter int LOG2N = 5
);
    logic             start;
    logic [LOG2N-1:0] twiddle_address;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-1:0] stage;
    logic             bf_valid;
    logic             bf_ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, bf_ready,
        output twiddle_address, addr_a, addr_b, stage, bf_valid, busy, done
    );

    modport slave (
        output start, bf_ready,
        input  twiddle_address, addr_a, addr_b, stage, bf_valid, busy, done
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place FFT address sequencer. Define FFT_STAGE_GAP_EN to insert a
// BF_LATENCY-cycle gap between stages for in-place read-after-write safety.
module fft_addr_gen #(
    parameter int N          = 32,
    parameter int BF_LATENCY = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    fft_addr_gen_if.master bus
);
    localparam int               LOG2N  = $clog2(N);
    localparam logic [LOG2N-1:0] LAST_S = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] LAST_J = LOG2N'(N / 2 - 1);
    localparam logic [LOG2N-1:0] ONE    = LOG2N'(1);
    localparam logic [LOG2N-1:0] ZERO   = LOG2N'(0);
`ifdef FFT_STAGE_GAP_EN
    localparam int               GW       = $clog2(BF_LATENCY + 1);
    localparam logic [GW-1:0]    GAP_LAST = GW'(BF_LATENCY - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
`ifdef FFT_STAGE_GAP_EN
        GAP   = 2'd3,
`endif
        FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] s_q, s_d, j_q, j_d;
    logic [LOG2N-1:0] a_q, a_d, b_q, b_d, stage_q, stage_d, k_q, k_d;
    logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d;
`ifdef FFT_STAGE_GAP_EN
    logic [GW-1:0]    gap_q, gap_d;
`endif
    logic [LOG2N-1:0] half_s, pos_s, grp_s, a_s, b_s, k_s;
    logic             adv_s;

    // Butterfly addresses and twiddle index derived from the live counters.
    always_comb begin
        half_s = ONE << s_q;
        pos_s  = j_q & (half_s - ONE);
        grp_s  = j_q >> s_q;
        a_s    = (grp_s << (s_q + ONE)) + pos_s;
        b_s    = a_s + half_s;
        k_s    = pos_s << (LAST_S - s_q);
    end

    // While stalled the ROM must keep seeing the presented butterfly's index.
    assign adv_s               = !valid_q || bus.bf_ready;
    assign bus.twiddle_address = adv_s ? k_s : k_q;
    assign bus.addr_a          = a_q;
    assign bus.addr_b          = b_q;
    assign bus.stage           = stage_q;
    assign bus.bf_valid        = valid_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

    // Next-state logic: issue on advance, wrap stages, drain before done.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        a_d     = a_q;
        b_d     = b_q;
        stage_d = stage_q;
        k_d     = k_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef FFT_STAGE_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && !done_q) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    s_d     = ZERO;
                    j_d     = ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (adv_s) begin
                    a_d     = a_s;
                    b_d     = b_s;
                    stage_d = s_q;
                    k_d     = k_s;
                    valid_d = 1'b1;
                    if (j_q == LAST_J) begin
                        j_d = ZERO;
                        if (s_q == LAST_S) begin
                            s_d     = ZERO;
                            state_d = FLUSH;
                        end else begin
                            s_d = s_q + ONE;
`ifdef FFT_STAGE_GAP_EN
                            state_d = GAP;
                            gap_d   = GW'(0);
`endif
                        end
                    end else begin
                        j_d = j_q + ONE;
                    end
                end else begin
                    state_d = RUN;
                end
            end
`ifdef FFT_STAGE_GAP_EN
            GAP: begin
                // Counting starts with the acceptance of the stage's last butterfly.
                if (adv_s) begin
                    valid_d = 1'b0;
                    if (gap_q == GAP_LAST) begin
                        state_d = RUN;
                        gap_d   = GW'(0);
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end else begin
                    state_d = GAP;
                end
            end
`endif
            FLUSH: begin
                if (adv_s) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= ZERO;
            j_q     <= ZERO;
            a_q     <= ZERO;
            b_q     <= ZERO;
            stage_q <= ZERO;
            k_q     <= ZERO;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FFT_STAGE_GAP_EN
            gap_q   <= GW'(0);
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FFT_STAGE_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end
endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: expected butterflies are queued per transform
// and popped on each acceptance; a registered ROM model checks twiddle alignment.
`timescale 1ns/1ps
module tb_fft_addr_gen;
    localparam int N          = 32;
    localparam int LOG2N      = 5;
    localparam int BF_LATENCY = 4;
`ifdef FFT_STAGE_GAP_EN
    localparam int GAP_LEN    = BF_LATENCY;
`else
    localparam int GAP_LEN    = 0;
`endif
    localparam int RUN_LEN    = (N / 2) * LOG2N + (LOG2N - 1) * GAP_LEN + 2;

    typedef struct {
        logic [LOG2N-1:0] s;
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [LOG2N-1:0] k;
    } bf_t;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic [LOG2N-1:0] rom_q;
    bf_t              exp_q[$];
    int               checks   = 0;
    int               failures = 0;

    fft_addr_gen_if #(.LOG2N(LOG2N)) bus();

    fft_addr_gen #(.N(N), .BF_LATENCY(BF_LATENCY)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Twiddle ROM stand-in: returns its address one cycle later.
    always @(posedge clock) rom_q <= bus.twiddle_address;

    // Expected order: stage outer, then group, then position within group.
    task automatic build_expected();
        exp_q.delete();
        for (int s = 0; s < LOG2N; s++) begin
            int half;
            half = 1 << s;
            for (int g = 0; g < N / (2 * half); g++) begin
                for (int p = 0; p < half; p++) begin
                    bf_t e;
                    e.s = LOG2N'(s);
                    e.a = LOG2N'(g * 2 * half + p);
                    e.b = LOG2N'(g * 2 * half + p + half);
                    e.k = LOG2N'(p * (N / (2 * half)));
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({bus.twiddle_address, bus.addr_a, bus.addr_b, bus.stage,
             bus.bf_valid, bus.busy, bus.done} !== {(4 * LOG2N + 3){1'b0}}) begin
            failures++;
            $display("FAIL %s outputs got tw=%0d a=%0d b=%0d st=%0d v=%0b busy=%0b done=%0b expected all 0",
                     tag, bus.twiddle_address, bus.addr_a, bus.addr_b, bus.stage,
                     bus.bf_valid, bus.busy, bus.done);
        end
    endtask

    // One full transform: start, drive ready (with optional stall), score every butterfly.
    task automatic run_fft(input int stall_idx, input int stall_len,
                           input int ign1, input int ign2, output int gaps);
        int  idx, stall_cnt, low_run, exp_done;
        bit  seen_valid, got_done;
        bf_t e;
        build_expected();
        idx = 0; stall_cnt = 0; low_run = 0; gaps = 0;
        seen_valid = 1'b0; got_done = 1'b0;
        exp_done = RUN_LEN + stall_len;
        @(negedge clock);
        bus.start = 1'b1;
        bus.bf_ready = 1'b1;
        for (int c = 1; c <= exp_done + 8; c++) begin
            @(negedge clock);
            bus.start = (c == ign1) || (c == ign2);
            bus.bf_ready = 1'b1;
            if (bus.bf_valid && idx == stall_idx && stall_cnt < stall_len) begin
                bus.bf_ready = 1'b0;
                stall_cnt++;
            end
            #1;
            if (c == 1) begin
                checks++;
                if (bus.twiddle_address !== LOG2N'(0) || bus.bf_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL first_cycle got tw=%0d valid=%0b expected tw=0 valid=0",
                             bus.twiddle_address, bus.bf_valid);
                end
            end
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                checks++;
                if (c != exp_done || bus.busy !== 1'b0) begin
                    failures++;
                    $display("FAIL done_timing got cycle=%0d busy=%0b expected cycle=%0d busy=0",
                             c, bus.busy, exp_done);
                end
                break;
            end
            checks++;
            if (bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL busy cycle=%0d got %0b expected 1", c, bus.busy);
            end
            if (bus.bf_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_butterfly cycle=%0d got a=%0d expected none", c, bus.addr_a);
                end else begin
                    e = exp_q[0];
                    checks++;
                    if (bus.addr_a !== e.a || bus.addr_b !== e.b || bus.stage !== e.s || rom_q !== e.k) begin
                        failures++;
                        $display("FAIL butterfly idx=%0d got s=%0d a=%0d b=%0d rom=%0d expected s=%0d a=%0d b=%0d k=%0d",
                                 idx, bus.stage, bus.addr_a, bus.addr_b, rom_q, e.s, e.a, e.b, e.k);
                    end
                    if (bus.bf_ready === 1'b0) begin
                        checks++;
                        if (bus.twiddle_address !== e.k) begin
                            failures++;
                            $display("FAIL stall_twiddle idx=%0d got %0d expected %0d",
                                     idx, bus.twiddle_address, e.k);
                        end
                    end else begin
                        void'(exp_q.pop_front());
                        idx++;
                    end
                end
                if (seen_valid && low_run > 0) begin
                    gaps++;
                    checks++;
                    if (low_run != GAP_LEN) begin
                        failures++;
                        $display("FAIL gap_length got %0d expected %0d", low_run, GAP_LEN);
                    end
                end
                low_run = 0;
                seen_valid = 1'b1;
            end else if (seen_valid) begin
                low_run++;
            end
        end
        if (!got_done) begin
            checks++; failures++;
            $display("FAIL done_timeout got no done expected cycle=%0d", exp_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL butterflies_left got %0d expected 0", exp_q.size());
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.bf_valid !== 1'b0) begin
                failures++;
                $display("FAIL after_done got done=%0b busy=%0b valid=%0b expected 0 0 0",
                         bus.done, bus.busy, bus.bf_valid);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.bf_ready = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check_all_zero("idle");
    endtask

    task automatic test_sequence();
        int gaps;
        run_fft(-1, 0, -1, -1, gaps);
    endtask

    task automatic test_stage_gap();
        int gaps;
        run_fft(-1, 0, -1, -1, gaps);
        checks++;
        if (gaps != ((GAP_LEN > 0) ? (LOG2N - 1) : 0)) begin
            failures++;
            $display("FAIL gap_count got %0d expected %0d", gaps, (GAP_LEN > 0) ? (LOG2N - 1) : 0);
        end
    endtask

    task automatic test_stall();
        int gaps;
        run_fft(2 * (N / 2) + 6, 3, -1, -1, gaps);
    endtask

    task automatic test_ignored_start();
        int gaps;
        run_fft(-1, 0, 20, RUN_LEN, gaps);
    endtask

    task automatic test_reset_mid_run();
        int gaps;
        int tgt;
        tgt = 2 + 2 * (N / 2) + 5 + 2 * GAP_LEN;
        @(negedge clock);
        bus.start = 1'b1;
        bus.bf_ready = 1'b1;
        for (int c = 1; c <= tgt; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        #1;
        checks++;
        if (bus.stage !== LOG2N'(2) || bus.addr_a !== LOG2N'(9) || bus.addr_b !== LOG2N'(13)) begin
            failures++;
            $display("FAIL pre_abort got s=%0d a=%0d b=%0d expected s=2 a=9 b=13",
                     bus.stage, bus.addr_a, bus.addr_b);
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock);
            #1;
            check_all_zero("post_abort");
        end
        run_fft(-1, 0, -1, -1, gaps);
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stage_gap();
        test_stall();
        test_ignored_start();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
